// File: rtl/mem_access_unit.sv
// Memory access stage: owns MAR/MDR/IR and sequences fixed-latency word/byte
// accesses to a synchronous memory, returning a one-cycle ready pulse.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | registers loadable, waiting for a read or write request
// S_ACCESS | memory access in flight, counting down the wait cycles
module mem_access_unit #(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [15:0] IR_RESET    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        marE,
  input  logic [15:0] addr_in,
  input  logic        mdrE,
  input  logic [15:0] mdr_in,
  input  logic        irE,
  input  logic        mem_rd_req,
  input  logic        memWriteE,
  input  logic        byte_acc,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mar_out,
  output logic [15:0] mdr_out,
  output logic [15:0] IR,
  output logic [15:0] mem_addr,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  output logic        mem_ready,
  output logic        unaligned
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [15:0] r_mar, r_mdr, r_ir;
  logic        r_is_wr, r_is_byte, r_unal;
  logic        w_idle, w_start, w_done;
  logic [15:0] w_mar_nxt;

  assign w_idle    = (r_state == S_IDLE);
  assign w_mar_nxt = (w_idle && marE) ? addr_in : r_mar;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_rd_req || memWriteE) begin
          w_start     = 1'b1;
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      S_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mar     <= 16'h0000;
      r_mdr     <= 16'h0000;
      r_ir      <= IR_RESET;
      r_is_wr   <= 1'b0;
      r_is_byte <= 1'b0;
      r_unal    <= 1'b0;
    end else begin
      r_mar <= w_mar_nxt;
      if (w_idle && mdrE)
        r_mdr <= mdr_in;
      else if (w_done && !r_is_wr)
        r_mdr <= mem_rdata;
      // IR takes the MDR value from before this edge
      if (w_idle && irE)
        r_ir <= r_mdr;
      if (w_start) begin
        r_is_wr   <= memWriteE;
        r_is_byte <= byte_acc;
      end
      r_unal <= w_start && !byte_acc && w_mar_nxt[0];
    end
  end

  assign mar_out   = r_mar;
  assign mdr_out   = r_mdr;
  assign IR        = r_ir;
  assign mem_addr  = {r_mar[15:1], 1'b0};
  assign mem_en    = (r_state == S_ACCESS);
  assign mem_we    = mem_en && r_is_wr;
  assign mem_ready = mem_en && (r_cnt == 4'd0);
  assign unaligned = r_unal;
  assign mem_wdata = r_is_byte ? {r_mdr[7:0], r_mdr[7:0]} : r_mdr;

  always_comb begin
    mem_be = 2'b00;
    if (mem_en)
      mem_be = !r_is_byte ? 2'b11 : (r_mar[0] ? 2'b10 : 2'b01);
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single accesses plus
// hand sequences for IR load, ignored strobes, back-to-back and mid-access reset.
module tb_mem_access_unit;

  localparam int W = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        marE, mdrE, irE, mem_rd_req, memWriteE, byte_acc;
  logic [15:0] addr_in, mdr_in, mem_rdata;
  logic [15:0] mar_out, mdr_out, IR, mem_addr, mem_wdata;
  logic        mem_en, mem_we, mem_ready, unaligned;
  logic [1:0]  mem_be;

  int n_checks = 0;
  int n_err    = 0;

  mem_access_unit #(.WAIT_CYCLES(W), .IR_RESET(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .marE(marE), .addr_in(addr_in), .mdrE(mdrE), .mdr_in(mdr_in), .irE(irE),
    .mem_rd_req(mem_rd_req), .memWriteE(memWriteE), .byte_acc(byte_acc),
    .mem_rdata(mem_rdata),
    .mar_out(mar_out), .mdr_out(mdr_out), .IR(IR), .mem_addr(mem_addr),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .unaligned(unaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        wr;
    logic        bt;
    logic [15:0] rdata;
    logic [15:0] exp_addr;
    logic [1:0]  exp_be;
    logic [15:0] exp_wdata;
    logic        exp_unal;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    marE = 1'b1; addr_in = v.addr; mdrE = 1'b1; mdr_in = v.data;
    step();
    marE = 1'b0; mdrE = 1'b0;
    chk("mar_load", mar_out, v.addr);
    chk("mdr_load", mdr_out, v.data);
    mem_rd_req = !v.wr; memWriteE = v.wr; byte_acc = v.bt; mem_rdata = v.rdata;
    step();
    mem_rd_req = 1'b0; memWriteE = 1'b0;
    for (int k = 1; k <= W; k++) begin
      chk("acc_en", {15'd0, mem_en}, 16'd1);
      chk("acc_we", {15'd0, mem_we}, {15'd0, v.wr});
      chk("acc_addr", mem_addr, v.exp_addr);
      chk("acc_ready", {15'd0, mem_ready}, {15'd0, (k == W)});
      chk("acc_unal", {15'd0, unaligned}, {15'd0, (k == 1) && v.exp_unal});
      if (v.wr) begin
        chk("acc_be", {14'd0, mem_be}, {14'd0, v.exp_be});
        chk("acc_wdata", mem_wdata, v.exp_wdata);
      end
      step();
    end
    chk("idle_en", {15'd0, mem_en}, 16'd0);
    chk("idle_ready", {15'd0, mem_ready}, 16'd0);
    chk("idle_be", {14'd0, mem_be}, 16'd0);
    chk("mdr_after", mdr_out, v.wr ? v.data : v.rdata);
  endtask

  initial begin
    //           addr      data      wr    bt    rdata     exp_addr  be     wdata     unal
    vecs[0] = '{16'h3000, 16'h0000, 1'b0, 1'b0, 16'h1A07, 16'h3000, 2'b11, 16'h0000, 1'b0};
    vecs[1] = '{16'h3001, 16'h00C5, 1'b1, 1'b1, 16'h0000, 16'h3000, 2'b10, 16'hC5C5, 1'b0};
    vecs[2] = '{16'h3000, 16'h00C5, 1'b1, 1'b1, 16'h0000, 16'h3000, 2'b01, 16'hC5C5, 1'b0};
    vecs[3] = '{16'h3003, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h3002, 2'b11, 16'h0000, 1'b1};
    vecs[4] = '{16'h1234, 16'hA55A, 1'b1, 1'b0, 16'h0000, 16'h1234, 2'b11, 16'hA55A, 1'b0};
    vecs[5] = '{16'h0011, 16'h0000, 1'b0, 1'b1, 16'h7F80, 16'h0010, 2'b10, 16'h0000, 1'b0};
    vecs[6] = '{16'h3005, 16'h0F0F, 1'b1, 1'b0, 16'h0000, 16'h3004, 2'b11, 16'h0F0F, 1'b1};

    reset = 1'b1;
    marE = 0; mdrE = 0; irE = 0; mem_rd_req = 0; memWriteE = 0; byte_acc = 0;
    addr_in = 0; mdr_in = 0; mem_rdata = 0;
    #3;
    chk("rst_mar", mar_out, 16'h0000);
    chk("rst_mdr", mdr_out, 16'h0000);
    chk("rst_ir", IR, 16'h0000);
    chk("rst_en", {15'd0, mem_en}, 16'd0);
    chk("rst_ready", {15'd0, mem_ready}, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    run_vec(vecs[0]);
    irE = 1'b1;
    step();
    irE = 1'b0;
    chk("ir_load", IR, 16'h1A07);

    for (int i = 1; i < 7; i++) run_vec(vecs[i]);

    // strobes during ACCESS must be ignored
    marE = 1'b1; addr_in = 16'h3000; mdrE = 1'b1; mdr_in = 16'h1111;
    step();
    marE = 1'b0; mdrE = 1'b0;
    memWriteE = 1'b1; byte_acc = 1'b0;
    step();
    memWriteE = 1'b0;
    marE = 1'b1; addr_in = 16'h5555; mdrE = 1'b1; mdr_in = 16'hFFFF; irE = 1'b1;
    step();
    marE = 1'b0; mdrE = 1'b0; irE = 1'b0;
    chk("ign_mar", mar_out, 16'h3000);
    chk("ign_mdr", mdr_out, 16'h1111);
    chk("ign_ir", IR, 16'h1A07);
    chk("ign_addr", mem_addr, 16'h3000);
    step();
    chk("ign_ready", {15'd0, mem_ready}, 16'd1);
    step();
    chk("ign_done", {15'd0, mem_en}, 16'd0);

    // read+write together: write wins; held read starts right after ready
    marE = 1'b1; addr_in = 16'h2000; mdrE = 1'b1; mdr_in = 16'h2222;
    step();
    marE = 1'b0; mdrE = 1'b0;
    mem_rd_req = 1'b1; memWriteE = 1'b1; byte_acc = 1'b0; mem_rdata = 16'h4321;
    step();
    memWriteE = 1'b0;
    chk("both_we", {15'd0, mem_we}, 16'd1);
    step();
    step();
    chk("both_ready", {15'd0, mem_ready}, 16'd1);
    chk("both_we3", {15'd0, mem_we}, 16'd1);
    step();
    chk("b2b_gap_en", {15'd0, mem_en}, 16'd0);
    chk("b2b_gap_mdr", mdr_out, 16'h2222);
    step();
    mem_rd_req = 1'b0;
    chk("b2b_en", {15'd0, mem_en}, 16'd1);
    chk("b2b_we", {15'd0, mem_we}, 16'd0);
    chk("b2b_rdy1", {15'd0, mem_ready}, 16'd0);
    step();
    chk("b2b_rdy2", {15'd0, mem_ready}, 16'd0);
    step();
    chk("b2b_rdy3", {15'd0, mem_ready}, 16'd1);
    step();
    chk("b2b_end", {15'd0, mem_en}, 16'd0);
    chk("b2b_mdr", mdr_out, 16'h4321);

    // async reset in the middle of an access
    marE = 1'b1; addr_in = 16'h3000;
    step();
    marE = 1'b0;
    mem_rd_req = 1'b1; mem_rdata = 16'h9999;
    step();
    mem_rd_req = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_en", {15'd0, mem_en}, 16'd0);
    chk("mid_rst_ready", {15'd0, mem_ready}, 16'd0);
    chk("mid_rst_mar", mar_out, 16'h0000);
    chk("mid_rst_mdr", mdr_out, 16'h0000);
    chk("mid_rst_ir", IR, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
